// File: rtl/vi_pkg.sv
// Shared types and constants for the vi core front end.
package vi_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } fetch_tag_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_stage_if;

    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;

    modport master (
        output imem_req_valid_o,
        output imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_rsp_valid_i,
        input  imem_rsp_data_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_req_addr_o,
        output imem_req_ready_i,
        output imem_rsp_valid_i,
        output imem_rsp_data_i
    );

endinterface

// File: rtl/vi_sync_fifo.sv
// Small synchronous FIFO with flush; head entry is read straight from storage.
module vi_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_W-1:0]      head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & ~empty;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC generation, credit-limited imem requests, epoch-tagged response filtering.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk_i,
    input  logic          rsn_i,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    fetch_stage_if.master imem,
    output logic [31:0]   fetch_instruction_o,
    output logic [31:0]   fetch_pc_o,
    output logic          fetch_valid_o
);

    import vi_pkg::fetch_tag_t;
    import vi_pkg::fetch_entry_t;
    import vi_pkg::align_word;

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [31:0]   pc;
    logic          epoch;
    fetch_tag_t    tag_in;
    fetch_tag_t    tag_head;
    fetch_entry_t  entry_in;
    fetch_entry_t  entry_head;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] buf_count;
    logic [SW-1:0] credits_used;
    logic          tag_full;
    logic          tag_empty;
    logic          buf_empty;
    logic          buf_full_unused;
    logic          req_valid;
    logic          accept;
    logic          rsp_keep;
    logic          buf_pop;

    // Every slot in flight or buffered consumes one credit, so the buffer can never overflow.
    assign credits_used = {1'b0, tag_count} + {1'b0, buf_count};
    assign req_valid    = ~rsn_i & ~redirect_i & ~tag_full & (credits_used < SW'(BUF_DEPTH));
    assign accept       = req_valid & imem.imem_req_ready_i;

    assign imem.imem_req_valid_o = req_valid;
    assign imem.imem_req_addr_o  = pc;

    // Responses from a previous epoch, or arriving alongside a redirect, are discarded.
    assign rsp_keep = imem.imem_rsp_valid_i & ~tag_empty & ~redirect_i & (tag_head.epoch == epoch);
    assign buf_pop  = fetch_valid_o & ~stall_i;

    assign tag_in   = '{pc: pc, epoch: epoch};
    assign entry_in = '{pc: tag_head.pc, instr: imem.imem_rsp_data_i};

    assign fetch_valid_o       = ~buf_empty;
    assign fetch_instruction_o = buf_empty ? NOP_INSTR : entry_head.instr;
    assign fetch_pc_o          = buf_empty ? 32'h0 : entry_head.pc;

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            pc    <= RESET_PC;
            epoch <= 1'b0;
        end else if (redirect_i) begin
            pc    <= align_word(redirect_pc_i);
            epoch <= ~epoch;
        end else if (accept) begin
            pc    <= pc + 32'd4;
        end
    end

    vi_sync_fifo #(
        .DATA_W ($bits(fetch_tag_t)),
        .DEPTH  (BUF_DEPTH)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst       (rsn_i),
        .push      (accept),
        .push_data (tag_in),
        .pop       (imem.imem_rsp_valid_i),
        .flush     (1'b0),
        .head_data (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    vi_sync_fifo #(
        .DATA_W ($bits(fetch_entry_t)),
        .DEPTH  (BUF_DEPTH)
    ) u_instr_buf (
        .clk       (clk_i),
        .rst       (rsn_i),
        .push      (rsp_keep),
        .push_data (entry_in),
        .pop       (buf_pop),
        .flush     (redirect_i),
        .head_data (entry_head),
        .full      (buf_full_unused),
        .empty     (buf_empty),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a stream-level model.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_assert++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
    end \
  end

module tb_fetch_stage;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rsn_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] fetch_instruction_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_valid_o;

  fetch_stage_if fs_if();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk_i               (clk),
    .rsn_i               (rsn_i),
    .stall_i             (stall_i),
    .redirect_i          (redirect_i),
    .redirect_pc_i       (redirect_pc_i),
    .imem                (fs_if),
    .fetch_instruction_o (fetch_instruction_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_valid_o       (fetch_valid_o)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        stall    = 1'b0;
  logic        redir    = 1'b0;
  logic        ready    = 1'b1;
  logic        rsp_block  = 1'b0;
  logic        mem_random = 1'b0;
  logic [31:0] redir_pc = 32'h0;

  // Model state: requests in flight (address, accept cycle, epoch), buffered count, next PCs.
  logic [31:0] mq_addr[$];
  int          mq_cyc[$];
  logic        mq_ep[$];
  logic        ep = 1'b0;
  int          occ = 0;
  logic [31:0] exp_out_pc = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_9E01;
  endfunction

  task automatic model_clear();
    mq_addr.delete();
    mq_cyc.delete();
    mq_ep.delete();
    ep         = 1'b0;
    occ        = 0;
    exp_out_pc = RESET_PC;
    exp_req_pc = RESET_PC;
  endtask

  task automatic do_reset(input int n);
    rsn_i                  = 1'b1;
    stall_i                = 1'b0;
    redirect_i             = 1'b0;
    redirect_pc_i          = 32'h0;
    fs_if.imem_req_ready_i = 1'b1;
    fs_if.imem_rsp_valid_i = 1'b0;
    fs_if.imem_rsp_data_i  = 32'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_assert++;
      if (fs_if.imem_req_valid_o !== 1'b0 || fetch_valid_o !== 1'b0 ||
          fetch_instruction_o !== NOP_INSTR || fetch_pc_o !== 32'h0) begin
        n_fail++;
        $error("FAIL reset_state: req_valid %0b fetch_valid %0b instr %0h pc %0h",
               fs_if.imem_req_valid_o, fetch_valid_o, fetch_instruction_o, fetch_pc_o);
      end
      @(posedge clk);
      #1;
    end
    rsn_i = 1'b0;
    stall = 1'b0;
    redir = 1'b0;
    ready = 1'b1;
    model_clear();
  endtask

  task automatic step();
    logic rsp;
    logic rsp_ep;
    logic exp_rv;
    logic accept;
    logic pop;
    logic keep;
    stall_i                = stall;
    redirect_i             = redir;
    redirect_pc_i          = redir_pc;
    fs_if.imem_req_ready_i = ready;
    rsp = 1'b0;
    if (!rsp_block && mq_addr.size() > 0 && mq_cyc[0] < cyc)
      rsp = mem_random ? ($urandom_range(0, 2) != 0) : 1'b1;
    fs_if.imem_rsp_valid_i = rsp;
    fs_if.imem_rsp_data_i  = rsp ? instr_of(mq_addr[0]) : $urandom();

    @(negedge clk);
    exp_rv = ((mq_addr.size() + occ) < BUF_DEPTH) && !redir;
    `CHK("req_valid", fs_if.imem_req_valid_o, exp_rv)
    if (exp_rv) begin
      `CHK("req_addr", fs_if.imem_req_addr_o, exp_req_pc)
    end
    `CHK("fetch_valid", fetch_valid_o, (occ > 0))
    if (occ > 0) begin
      `CHK("fetch_pc", fetch_pc_o, exp_out_pc)
      `CHK("fetch_instr", fetch_instruction_o, instr_of(exp_out_pc))
    end else begin
      `CHK("idle_pc", fetch_pc_o, 32'h0)
      `CHK("idle_instr", fetch_instruction_o, NOP_INSTR)
    end
    accept = exp_rv && ready;
    pop    = (occ > 0) && !stall && !redir;
    rsp_ep = rsp ? mq_ep[0] : 1'b0;
    keep   = rsp && (rsp_ep == ep) && !redir;

    @(posedge clk);
    #1;
    cyc++;
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_cyc.pop_front());
      void'(mq_ep.pop_front());
    end
    if (accept) begin
      mq_addr.push_back(exp_req_pc);
      mq_cyc.push_back(cyc - 1);
      mq_ep.push_back(ep);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (redir) begin
      occ        = 0;
      ep         = ~ep;
      exp_req_pc = {redir_pc[31:2], 2'b00};
      exp_out_pc = {redir_pc[31:2], 2'b00};
    end else begin
      occ = occ + int'(keep) - int'(pop);
      if (pop) exp_out_pc = exp_out_pc + 32'd4;
    end
  endtask

  initial begin
    do_reset(3);
    repeat (8) step();

    stall = 1'b1;
    repeat (4) step();
    stall = 1'b0;
    repeat (4) step();

    ready = 1'b0;
    repeat (5) step();
    ready = 1'b1;
    repeat (4) step();

    rsp_block = 1'b1;
    repeat (3) step();
    rsp_block = 1'b0;
    redir     = 1'b1;
    redir_pc  = 32'h0000_2000;
    step();
    redir = 1'b0;
    repeat (6) step();

    stall    = 1'b1;
    redir    = 1'b1;
    redir_pc = 32'h0000_2002;
    step();
    redir = 1'b0;
    repeat (2) step();
    stall = 1'b0;
    repeat (5) step();

    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFF8;
    step();
    redir = 1'b0;
    repeat (8) step();

    mem_random = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 3) != 0);
      redir    = ($urandom_range(0, 29) == 0);
      redir_pc = $urandom();
      step();
    end
    redir      = 1'b0;
    stall      = 1'b0;
    ready      = 1'b1;
    mem_random = 1'b0;

    do_reset(2);
    for (int i = 0; i < 40 && exp_req_pc != 32'h0000_1010; i++) step();
    n_assert++;
    if (exp_req_pc !== 32'h0000_1010) begin
      n_fail++;
      $error("FAIL wait_expired: pc 0x1010 not reached, observed %0h", exp_req_pc);
    end
    do_reset(3);
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`undef CHK
